// File: rtl/fpu_cmp_pkg.sv
// Shared definitions for the FPU ordering comparators: sequencer states,
// default float geometry and field-level classification helpers.
package fpu_cmp_pkg;

    localparam int DEF_PRECISION     = 32;
    localparam int DEF_EXP_SIZE      = 8;
    localparam int DEF_MANTISSA_SIZE = 23;

    // Helpers take fields zero-extended to this width so one function body
    // serves every float geometry up to double precision.
    localparam int FIELD_W = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLASSIFY = 2'd1,
        SCAN     = 2'd2,
        DONE     = 2'd3
    } state_t;

    // NaN: exponent field all ones with a non-zero mantissa.
    function automatic logic is_nan(
        input logic [FIELD_W-1:0] exp_field,
        input logic [FIELD_W-1:0] exp_all_ones,
        input logic [FIELD_W-1:0] man_field
    );
        return (exp_field == exp_all_ones) && (man_field != '0);
    endfunction

    // Zero of either sign: every magnitude bit clear.
    function automatic logic is_zero(
        input logic [FIELD_W-1:0] magnitude
    );
        return (magnitude == '0);
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational classifier for one IEEE-754 operand: sign, NaN and zero flags.
module fp_classify
    import fpu_cmp_pkg::*;
#(
    parameter int precision     = DEF_PRECISION,
    parameter int exp_size      = DEF_EXP_SIZE,
    parameter int mantissa_size = DEF_MANTISSA_SIZE
) (
    input  logic [precision-1:0] i_fp,
    output logic                 o_sign,
    output logic                 o_is_nan,
    output logic                 o_is_zero
);

    localparam logic [FIELD_W-1:0] EXP_ALL_ONES = (64'd1 << exp_size) - 64'd1;

    logic [FIELD_W-1:0] w_exp;
    logic [FIELD_W-1:0] w_man;
    logic [FIELD_W-1:0] w_mag;

    assign w_exp = {{(FIELD_W-exp_size){1'b0}}, i_fp[precision-2 -: exp_size]};
    assign w_man = {{(FIELD_W-mantissa_size){1'b0}}, i_fp[mantissa_size-1:0]};
    assign w_mag = {{(FIELD_W-precision+1){1'b0}}, i_fp[precision-2:0]};

    assign o_sign    = i_fp[precision-1];
    assign o_is_nan  = is_nan(w_exp, EXP_ALL_ONES, w_man);
    assign o_is_zero = is_zero(w_mag);

endmodule

// File: rtl/lesser_seq.sv
// Multi-cycle IEEE-754 a <= b comparator with start/done handshake.
// Special cases resolve in one classify cycle; otherwise magnitudes are
// compared bit-serially MSB first under a down-counter.
// Optional macro LESSER_EARLY_EXIT_EN: leave the scan at the first differing
// bit instead of always walking every magnitude bit (result is identical).
module lesser_seq
    import fpu_cmp_pkg::*;
#(
    parameter int precision     = DEF_PRECISION,
    parameter int exp_size      = DEF_EXP_SIZE,
    parameter int mantissa_size = DEF_MANTISSA_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [precision-1:0] fp_a,
    input  logic [precision-1:0] fp_b,
    output logic                 busy,
    output logic                 res,
    output logic                 nan_exception,
    output logic                 done
);

    localparam int               CNT_W   = $clog2(precision);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(precision - 2);

    state_t r_state;
    state_t w_next_state;

    logic [precision-1:0] r_a;
    logic [precision-1:0] r_b;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_res;
    logic                 r_nan;
    logic                 r_found;

    logic w_sign_a;
    logic w_sign_b;
    logic w_nan_a;
    logic w_nan_b;
    logic w_zero_a;
    logic w_zero_b;
    logic w_special;
    logic w_bit_a;
    logic w_bit_b;
    logic w_bit_diff;
    logic w_last_bit;
    logic w_scan_exit;

    fp_classify #(
        .precision    (precision),
        .exp_size     (exp_size),
        .mantissa_size(mantissa_size)
    ) u_class_a (
        .i_fp     (r_a),
        .o_sign   (w_sign_a),
        .o_is_nan (w_nan_a),
        .o_is_zero(w_zero_a)
    );

    fp_classify #(
        .precision    (precision),
        .exp_size     (exp_size),
        .mantissa_size(mantissa_size)
    ) u_class_b (
        .i_fp     (r_b),
        .o_sign   (w_sign_b),
        .o_is_nan (w_nan_b),
        .o_is_zero(w_zero_b)
    );

    // Any of these decides the result without a magnitude scan.
    assign w_special = w_nan_a | w_nan_b | (w_zero_a & w_zero_b) | (w_sign_a ^ w_sign_b);

    assign w_bit_a    = r_a[r_cnt];
    assign w_bit_b    = r_b[r_cnt];
    assign w_bit_diff = w_bit_a ^ w_bit_b;
    assign w_last_bit = (r_cnt == '0);

`ifdef LESSER_EARLY_EXIT_EN
    assign w_scan_exit = w_last_bit | w_bit_diff;
`else
    assign w_scan_exit = w_last_bit;
`endif

    // State register, abandoned immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; start is only honoured from IDLE.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (w_special) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SCAN;
                end
            end
            SCAN: begin
                if (w_scan_exit) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, classification result, serial scan and sticky decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_res   <= 1'b0;
            r_nan   <= 1'b0;
            r_found <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= fp_a;
                        r_b     <= fp_b;
                        r_res   <= 1'b0;
                        r_nan   <= 1'b0;
                        r_found <= 1'b0;
                    end
                end
                CLASSIFY: begin
                    if (w_nan_a | w_nan_b) begin
                        r_res <= 1'b0;
                        r_nan <= 1'b1;
                    end else if (w_zero_a & w_zero_b) begin
                        r_res <= 1'b1;
                    end else if (w_sign_a ^ w_sign_b) begin
                        r_res <= w_sign_a;
                    end else begin
                        r_cnt <= CNT_TOP;
                    end
                end
                SCAN: begin
                    if (!r_found && w_bit_diff) begin
                        r_res   <= (~w_bit_a) ^ w_sign_a;
                        r_found <= 1'b1;
                    end else if (!r_found && w_last_bit) begin
                        r_res <= 1'b1;
                    end
                    if (!w_last_bit) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake and result outputs decoded from state and held registers.
    always_comb begin
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        res           = r_res;
        nan_exception = r_nan;
    end

endmodule

// File: tb/tb_lesser_seq.sv
// Self-checking bench for lesser_seq: expected results are queued when a
// comparison is issued and checked when done pulses.
module tb_lesser_seq;

   typedef struct packed {
      logic       r;
      logic       n;
      logic [7:0] lat;
   } expT;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] fpA;
   logic [31:0] fpB;
   logic        busy;
   logic        res;
   logic        nanException;
   logic        done;

   int  testsRun    = 0;
   int  testsFailed = 0;
   expT scoreQ[$];

   lesser_seq dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .fp_a         (fpA),
      .fp_b         (fpB),
      .busy         (busy),
      .res          (res),
      .nan_exception(nanException),
      .done         (done)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Count one comparison and report it when it disagrees.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Reference a <= b from the IEEE-754 ordering rules, plus the cycle of done.
   function automatic void modelCompare(input logic [31:0] a, input logic [31:0] b,
                                        output logic expRes, output logic expNan, output int expLat);
      logic [30:0] magA;
      logic [30:0] magB;
      logic        nanA;
      logic        nanB;
      int          firstDiff;
      magA = a[30:0];
      magB = b[30:0];
      nanA = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      nanB = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      expNan = 1'b0;
      expLat = 2;
      if (nanA || nanB) begin
         expRes = 1'b0;
         expNan = 1'b1;
      end else if (magA == 31'd0 && magB == 31'd0) begin
         expRes = 1'b1;
      end else if (a[31] != b[31]) begin
         expRes = a[31];
      end else if (magA == magB) begin
         expRes = 1'b1;
         expLat = 2 + 31;
      end else begin
         expRes = (magA < magB) ^ a[31];
         firstDiff = 0;
         for (int i = 0; i < 31; i++) begin
            if (magA[i] != magB[i]) firstDiff = i;
         end
`ifdef LESSER_EARLY_EXIT_EN
         expLat = 2 + (31 - firstDiff);
`else
         expLat = 2 + 31;
`endif
      end
   endfunction

   // Issue one comparison, optionally poking start while busy, then check it.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit pulseStart);
      expT  e;
      logic er;
      logic en;
      int   el;
      int   cycles;
      modelCompare(a, b, er, en, el);
      e.r   = er;
      e.n   = en;
      e.lat = 8'(el);
      scoreQ.push_back(e);
      @(negedge clk);
      fpA   = a;
      fpB   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      fpA    = ~a;
      fpB    = $urandom;
      cycles = 1;
      checkOutput("busyAfterStart", 32'(busy), 32'd1);
      while (!done && cycles < 100) begin
         start = (pulseStart && cycles == 5);
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;
      e = scoreQ.pop_front();
      if (!done) begin
         checkOutput("doneTimeout", 32'd0, 32'd1);
      end else begin
         checkOutput("res", 32'(res), 32'(e.r));
         checkOutput("nanException", 32'(nanException), 32'(e.n));
         checkOutput("latency", 32'(cycles), 32'(e.lat));
      end
      if (pulseStart) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("donePulseWidth", 32'(done), 32'd0);
      checkOutput("idleAfterDone", 32'(busy), 32'd0);
      checkOutput("resHeld", 32'(res), 32'(e.r));
      checkOutput("nanHeld", 32'(nanException), 32'(e.n));
      if (pulseStart) begin
         repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("ignoredStartNoDone", 32'(done), 32'd0);
            checkOutput("ignoredStartIdle", 32'(busy), 32'd0);
         end
      end
   endtask

   // Main sequence: reset values, directed cases, random cases, mid-scan reset.
   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      reset = 1'b0;
      start = 1'b0;
      fpA   = '0;
      fpB   = '0;
      #2;
      checkOutput("resetBusy", 32'(busy), 32'd0);
      checkOutput("resetRes", 32'(res), 32'd0);
      checkOutput("resetNan", 32'(nanException), 32'd0);
      checkOutput("resetDone", 32'(done), 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;

      applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
      applyStimulus(32'h40000000, 32'h3F800000, 1'b0);
      applyStimulus(32'hC0000000, 32'hBF800000, 1'b0);
      applyStimulus(32'h00000000, 32'h80000000, 1'b0);
      applyStimulus(32'hC0000000, 32'h3F800000, 1'b0);
      applyStimulus(32'h3F800000, 32'hC0000000, 1'b0);
      applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0);
      applyStimulus(32'h3F800000, 32'h7FC00000, 1'b0);
      applyStimulus(32'h7F800000, 32'h7F7FFFFF, 1'b0);
      applyStimulus(32'h3F800001, 32'h3F800000, 1'b0);
      applyStimulus(32'h3F800001, 32'h3F800001, 1'b1);

      for (int i = 0; i < 6; i++) begin
         ra = $urandom;
         if (i < 4) rb = ra ^ (32'h1 << $urandom_range(0, 30));
         else       rb = $urandom;
         applyStimulus(ra, rb, 1'b0);
      end

      @(negedge clk);
      fpA   = 32'h3F800001;
      fpB   = 32'h3F800001;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      checkOutput("busyBeforeReset", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midResetBusy", 32'(busy), 32'd0);
      checkOutput("midResetRes", 32'(res), 32'd0);
      checkOutput("midResetDone", 32'(done), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         checkOutput("heldResetDone", 32'(done), 32'd0);
      end
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(32'h3F800000, 32'h40000000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
